// File: rtl/vga_sync_recover.sv
// Sink-side VGA timing recovery: measures line/frame length from incoming syncs,
// locks after two consistent frames and regenerates ready plus pixel addresses.
// Optional 3-sample sync glitch filter: define VGA_RX_GLITCH_FILTER_EN.
module vga_sync_recover #(
    parameter int H_BACK   = 216,
    parameter int H_ACTIVE = 800,
    parameter int V_BACK   = 27,
    parameter int V_ACTIVE = 600,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_sig,
    input  logic        vsync_sig,
    output logic        locked,
    output logic        lock_err,
    output logic        ready,
    output logic [10:0] column_addr_sig,
    output logic [10:0] row_addr_sig,
    output logic [10:0] h_total,
    output logic [10:0] v_total
);

    localparam logic [10:0] CNT_MAX = 11'h7FF;
    localparam logic [11:0] H_LO    = 12'(H_BACK);
    localparam logic [11:0] H_HI    = 12'(H_BACK + H_ACTIVE);
    localparam logic [11:0] V_LO    = 12'(V_BACK);
    localparam logic [11:0] V_HI    = 12'(V_BACK + V_ACTIVE);

    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

    function automatic logic [10:0] sat_inc(input logic [10:0] x);
        return (x == CNT_MAX) ? x : x + 11'd1;
    endfunction

    logic [1:0]  hs_sync_q, vs_sync_q;
    logic        hs_norm, vs_norm;
    logic        hs_lvl, vs_lvl;
    logic        hs_lvl_q, vs_lvl_q;
    logic        hs_edge_q, vs_edge_q;
    logic [10:0] h_cnt_q, v_cnt_q;
    logic [10:0] h_len, v_len;
    logic        h_bad, v_bad, timeout, lock_fail, in_window;
    state_t      state_q;
    logic        locked_q, lock_err_q, ready_q;
    logic [10:0] col_q, row_q, h_total_q, v_total_q;

    // Synchronizers idle at the inactive raw level so reset never fakes an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_sync_q <= {2{~SYNC_POL}};
            vs_sync_q <= {2{~SYNC_POL}};
        end else begin
            hs_sync_q <= {hs_sync_q[0], hsync_sig};
            vs_sync_q <= {vs_sync_q[0], vsync_sig};
        end
    end

    assign hs_norm = hs_sync_q[1] ^ ~SYNC_POL;
    assign vs_norm = vs_sync_q[1] ^ ~SYNC_POL;

`ifdef VGA_RX_GLITCH_FILTER_EN
    logic [1:0] hs_hist_q, vs_hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_hist_q <= 2'b00;
            vs_hist_q <= 2'b00;
        end else begin
            hs_hist_q <= {hs_hist_q[0], hs_norm};
            vs_hist_q <= {vs_hist_q[0], vs_norm};
        end
    end

    // Level follows the input only once the current and two previous samples agree
    always_comb begin
        hs_lvl = hs_lvl_q;
        vs_lvl = vs_lvl_q;
        if (hs_hist_q == {2{hs_norm}}) hs_lvl = hs_norm;
        if (vs_hist_q == {2{vs_norm}}) vs_lvl = vs_norm;
    end
`else
    assign hs_lvl = hs_norm;
    assign vs_lvl = vs_norm;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_lvl_q  <= 1'b0;
            vs_lvl_q  <= 1'b0;
            hs_edge_q <= 1'b0;
            vs_edge_q <= 1'b0;
        end else begin
            hs_lvl_q  <= hs_lvl;
            vs_lvl_q  <= vs_lvl;
            hs_edge_q <= hs_lvl & ~hs_lvl_q;
            vs_edge_q <= vs_lvl & ~vs_lvl_q;
        end
    end

    // Vsync clear takes priority over the line increment in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= hs_edge_q ? 11'd0 : sat_inc(h_cnt_q);
            if (vs_edge_q)      v_cnt_q <= '0;
            else if (hs_edge_q) v_cnt_q <= sat_inc(v_cnt_q);
        end
    end

    always_comb begin
        h_len     = sat_inc(h_cnt_q);
        v_len     = sat_inc(v_cnt_q);
        h_bad     = hs_edge_q && (({1'b0, h_cnt_q} + 12'd1) != {1'b0, h_total_q});
        v_bad     = vs_edge_q && (({1'b0, v_cnt_q} + 12'd1) != {1'b0, v_total_q});
        timeout   = !hs_edge_q && (h_cnt_q == CNT_MAX);
        lock_fail = h_bad || v_bad || timeout;
        in_window = ({1'b0, h_cnt_q} >= H_LO) && ({1'b0, h_cnt_q} < H_HI) &&
                    ({1'b0, v_cnt_q} >= V_LO) && ({1'b0, v_cnt_q} < V_HI);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SEARCH;
            locked_q   <= 1'b0;
            lock_err_q <= 1'b0;
            ready_q    <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            h_total_q  <= '0;
            v_total_q  <= '0;
        end else begin
            lock_err_q <= 1'b0;
            ready_q    <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            case (state_q)
                SEARCH: begin
                    if (vs_edge_q) state_q <= MEASURE;
                end
                MEASURE: begin
                    if (hs_edge_q) h_total_q <= h_len;
                    if (vs_edge_q) begin
                        v_total_q <= v_len;
                        state_q   <= VERIFY;
                    end
                end
                VERIFY: begin
                    if (h_bad || v_bad) begin
                        if (hs_edge_q) h_total_q <= h_len;
                        if (vs_edge_q) v_total_q <= v_len;
                        state_q <= MEASURE;
                    end else if (vs_edge_q) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (lock_fail) begin
                        state_q    <= SEARCH;
                        locked_q   <= 1'b0;
                        lock_err_q <= 1'b1;
                    end else if (in_window) begin
                        ready_q <= 1'b1;
                        col_q   <= h_cnt_q - H_LO[10:0];
                        row_q   <= v_cnt_q - V_LO[10:0];
                    end
                end
                default: state_q <= SEARCH;
            endcase
        end
    end

    assign locked          = locked_q;
    assign lock_err        = lock_err_q;
    assign ready           = ready_q;
    assign column_addr_sig = col_q;
    assign row_addr_sig    = row_q;
    assign h_total         = h_total_q;
    assign v_total         = v_total_q;

endmodule

// File: tb/tb_vga_sync_recover.sv
// Directed bench for vga_sync_recover using a scaled-down raster (32x10 clocks/lines)
// so lock, fault, timeout and reset scenarios all fit in a short run.
module tb_vga_sync_recover;

    localparam int HB = 8, HA = 16, VB = 3, VA = 5;
    localparam int HT = 32, HS = 4, VT = 10, VS = 1;
`ifdef VGA_RX_GLITCH_FILTER_EN
    localparam int P = 5;
`else
    localparam int P = 3;
`endif
    localparam int LAT = P + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hs = 1'b0, vs = 1'b0;
    logic hs_n, vs_n;
    logic locked_p, lock_err_p, ready_p;
    logic [10:0] col_p, row_p, ht_p, vt_p;
    logic locked_n, lock_err_n, ready_n;
    logic [10:0] col_n, row_n, ht_n, vt_n;

    assign hs_n = ~hs;
    assign vs_n = ~vs;

    always #5 clk = ~clk;

    vga_sync_recover #(.H_BACK(HB), .H_ACTIVE(HA), .V_BACK(VB), .V_ACTIVE(VA), .SYNC_POL(1'b1)) u_dut (
        .clk(clk), .rst(rst), .hsync_sig(hs), .vsync_sig(vs),
        .locked(locked_p), .lock_err(lock_err_p), .ready(ready_p),
        .column_addr_sig(col_p), .row_addr_sig(row_p), .h_total(ht_p), .v_total(vt_p)
    );

    vga_sync_recover #(.H_BACK(HB), .H_ACTIVE(HA), .V_BACK(VB), .V_ACTIVE(VA), .SYNC_POL(1'b0)) u_dut_n (
        .clk(clk), .rst(rst), .hsync_sig(hs_n), .vsync_sig(vs_n),
        .locked(locked_n), .lock_err(lock_err_n), .ready(ready_n),
        .column_addr_sig(col_n), .row_addr_sig(row_n), .h_total(ht_n), .v_total(vt_n)
    );

    int total = 0, bad = 0;
    int cyc = 0, last_hs_cyc = 0, vs_seen = 0, vs3_cyc = 0, pol_diff = 0;
    int px = 0, ln = 5;
    bit short_req = 0, glitch_req = 0, kill = 0;
    logic prev_hs = 1'b0, prev_vs = 1'b0;
    int hpx [0:7];
    int hln [0:7];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // One clock: record what this edge sampled, then drive the next raster pixel.
    task automatic tick();
        int len;
        bit g;
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 7; i > 0; i--) begin
            hpx[i] = hpx[i-1];
            hln[i] = hln[i-1];
        end
        hpx[0] = px;
        hln[0] = ln;
        if (hs && !prev_hs) last_hs_cyc = cyc;
        if (vs && !prev_vs && vs_seen < 3) begin
            vs_seen++;
            if (vs_seen == 3) vs3_cyc = cyc;
        end
        prev_hs = hs;
        prev_vs = vs;
        if ({locked_p, lock_err_p, ready_p, col_p, row_p, ht_p, vt_p} !==
            {locked_n, lock_err_n, ready_n, col_n, row_n, ht_n, vt_n}) pol_diff++;
        len = (short_req && ln == 1) ? HT - 1 : HT;
        if (px == len - 1) begin
            px = 0;
            if (len != HT) short_req = 0;
            ln = (ln == VT - 1) ? 0 : ln + 1;
        end else begin
            px++;
        end
        g = glitch_req && ln == 5 && px == HB + 8;
        if (g) glitch_req = 0;
        hs = !kill && (px < HS || g);
        vs = !kill && (ln < VS);
    endtask

    task automatic wait_lock(input string tag);
        int n;
        n = 0;
        vs_seen = 0;
        vs3_cyc = -100000;
        while (!locked_p && n < 6000) begin
            tick();
            n++;
        end
        if (!locked_p) chk({tag, "_timeout"}, 0, 1);
        else chk(tag, cyc - vs3_cyc, P);
    endtask

    task automatic wait_err(input string tag, input int budget, input int exp_lat);
        int n;
        n = 0;
        while (!lock_err_p && n < budget) begin
            tick();
            n++;
        end
        if (!lock_err_p) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            chk({tag, "_lat"}, cyc - last_hs_cyc, exp_lat);
            chk({tag, "_locked"}, 32'(locked_p), 0);
            chk({tag, "_ready"}, 32'(ready_p), 0);
            tick();
            chk({tag, "_pulse"}, 32'(lock_err_p), 0);
        end
    endtask

    // One full frame compared against the raster delayed by the pipeline latency.
    task automatic frame_check(input string tag);
        int errs, rdy, cmax, rmax, nerr, epx, eln;
        logic er;
        errs = 0; rdy = 0; cmax = 0; rmax = 0; nerr = 0;
        repeat (HT * VT) begin
            tick();
            epx = hpx[LAT];
            eln = hln[LAT];
            er  = (epx >= HB && epx < HB + HA && eln >= VB && eln < VB + VA);
            if (ready_p !== er) errs++;
            else if (er && (32'(col_p) != epx - HB || 32'(row_p) != eln - VB)) errs++;
            else if (!er && (col_p !== 11'd0 || row_p !== 11'd0)) errs++;
            if (ready_p === 1'b1) begin
                rdy++;
                if (32'(col_p) > cmax) cmax = 32'(col_p);
                if (32'(row_p) > rmax) rmax = 32'(row_p);
            end
            if (lock_err_p !== 1'b0) nerr++;
        end
        chk({tag, "_model"}, errs, 0);
        chk({tag, "_ready_cnt"}, rdy, HA * VA);
        chk({tag, "_col_max"}, cmax, HA - 1);
        chk({tag, "_row_max"}, rmax, VA - 1);
        chk({tag, "_no_err"}, nerr, 0);
        chk({tag, "_locked"}, 32'(locked_p), 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_locked"}, 32'(locked_p), 0);
        chk({tag, "_lock_err"}, 32'(lock_err_p), 0);
        chk({tag, "_ready"}, 32'(ready_p), 0);
        chk({tag, "_col"}, 32'(col_p), 0);
        chk({tag, "_row"}, 32'(row_p), 0);
        chk({tag, "_h_total"}, 32'(ht_p), 0);
        chk({tag, "_v_total"}, 32'(vt_p), 0);
    endtask

    task automatic goto_line5();
        int n;
        n = 0;
        while (!(px == HS + 2 && ln == 5) && n < 2 * HT * VT) begin
            tick();
            n++;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            hpx[i] = 0;
            hln[i] = 0;
        end
        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b0;

        wait_lock("lock1");
        chk("h_total", 32'(ht_p), HT);
        chk("v_total", 32'(vt_p), VT);
        frame_check("nominal");

        short_req = 1;
        wait_err("linefault", 800, P);
        chk("linefault_h_total_kept", 32'(ht_p), HT);
        wait_lock("relock_line");
        chk("relock_line_h_total", 32'(ht_p), HT);

        glitch_req = 1;
`ifdef VGA_RX_GLITCH_FILTER_EN
        frame_check("glitch_filtered");
`else
        wait_err("glitch", 800, P);
        wait_lock("relock_glitch");
`endif

        goto_line5();
        kill = 1;
        wait_err("hsloss", 2400, P + 2048);
        chk("hsloss_h_total_kept", 32'(ht_p), HT);
        chk("hsloss_v_total_kept", 32'(vt_p), VT);
        goto_line5();
        kill = 0;
        wait_lock("relock_hs");
        frame_check("after_hsloss");

        goto_line5();
        chk("pre_reset_locked", 32'(locked_p), 1);
        rst = 1'b1;
        tick();
        check_reset_vals("midreset");
        rst = 1'b0;
        wait_lock("relock_rst");
        chk("relock_rst_h_total", 32'(ht_p), HT);
        chk("relock_rst_v_total", 32'(vt_p), VT);
        frame_check("final");

        chk("polarity_match", pol_diff, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
